change_dispenser: RTL and testbench
===================================

# change_dispenser

Controller that pays out a change amount from the vending machine's coin-denomination hoppers (10, 5, 1). It takes the residual `total_coin` value at the change step and runs a greedy, largest-coin-first payout. Each coin is a req/ack handshake with the hopper mechanics. Hoppers that are empty or unresponsive are skipped, and any unpaid amount is reported.

## Interface
- `W`, 32: width of amount, paid and remaining values.
- `TIMEOUT`, 15: cycles `eject_req` is held without `eject_ack` before that hopper is declared failed (≥2).
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: payout request, sampled only in IDLE.
- `amount` in W: change to pay, latched when `start` is accepted.
- `empty` in 3: hopper-empty flags. [2]=10, [1]=5, [0]=1.
- `eject_ack` in 1: hopper has dropped one coin. Level, returns low after `eject_req` falls.
- `eject_req` out 1: eject one coin of `eject_sel`.
- `eject_sel` out 2: 2'b01=10, 2'b10=5, 2'b11=1, 2'b00=none. Stable while `eject_req`=1.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle pulse at end of transaction.
- `fault` out 1: last transaction ended with `remaining`≠0. Held until the next accepted `start`.
- `paid` out W: running total ejected in this transaction.
- `remaining` out W: amount still owed.

## Operation
- States: IDLE, SELECT, REQ, WAIT_REL, DONE.
- IDLE
  - `start`=1 at an edge: `remaining`←`amount`, `paid`←0, `fault`←0, failed-mask←0, go to SELECT.
  - `start` is ignored in every other state.
- SELECT: picks the largest denomination d with `remaining`≥d, `empty` bit 0, and failed-mask bit 0.
  - Found: `eject_sel`←code(d), `eject_req`←1, timeout counter←0, go to REQ.
  - `remaining`=0: go to DONE, `fault`←0.
  - `remaining`>0 and no eligible d: go to DONE, `fault`←1.
  - `empty` is sampled only in SELECT. A hopper going empty during REQ does not abort the current coin.
- REQ
  - `eject_ack`=1 at an edge: `remaining`←`remaining`−d, `paid`←`paid`+d, `eject_req`←0, go to WAIT_REL.
  - Otherwise the counter increments. If the counter reaches `TIMEOUT`−1 without ack: set failed-mask bit for d, `eject_req`←0, go to SELECT with no amount change.
- WAIT_REL: waits for `eject_ack`=0 sampled, then goes to SELECT. No timeout here.
- DONE: `done`=1 for this cycle only, then go to IDLE. `paid`, `remaining` and `fault` hold until the next `start`.
- Outputs:
  - `busy`=1 in SELECT, REQ, WAIT_REL and DONE.
  - `eject_sel` returns to 2'b00 whenever `eject_req`=0.
- Arithmetic
  - Unsigned W-bit.
  - Invariant: `paid`+`remaining` = latched `amount`.
  - Subtraction never underflows, because d ≤ `remaining` is guaranteed by SELECT.
- Reset (`reset`=0, any time, including mid-handshake):
  - State→IDLE.
  - `eject_req`, `eject_sel`, `busy`, `done`, `fault`→0.
  - `paid`, `remaining`→0.
  - Failed-mask and counter cleared.
  - `eject_req` falls asynchronously.

## Timing
- `start` sampled at edge k: `busy`=1 after edge k.
- First `eject_req`=1 after edge k+1.
- `amount`=0: `done` is high during the cycle after edge k+1. No eject occurs.
- Ack sampled at edge m: `eject_req`=0, and `paid`/`remaining` are updated, after edge m.
- Ack low sampled at edge n: SELECT after n. Next `eject_req` after n+1.
- Minimum per-coin period, with ack high 1 cycle after req and low 1 cycle after release: 4 cycles.
- Timeout: `eject_req` is high for exactly `TIMEOUT` cycles, then low for at least 1 cycle before any other denomination is requested.
- `done` is asserted for exactly 1 cycle. `busy` falls on the edge after `done`.

## Test plan
- **37, all hoppers full, ack 1 cycle after req**
  - `eject_sel` sequence: 01,01,01,10,11,11.
  - End: `paid`=37, `remaining`=0, `fault`=0, one `done` pulse.
- **15, `empty`=3'b100**
  - Sequence: 10,10,10.
  - End: `paid`=15, `fault`=0.
- **3, `empty`=3'b001**
  - No `eject_req`.
  - `done` 2 cycles after start, `fault`=1, `remaining`=3, `paid`=0.
- **10, 10-hopper never acks, TIMEOUT=15**
  - `eject_req`(01) is high for 15 cycles then drops.
  - Then the sequence is 10,10 (two 5-coins).
  - End: `paid`=10, `fault`=0.
- **0**
  - `done` pulse with `paid`=0 and `fault`=0.
  - A `start` pulse during an active transaction is ignored, with the latched amount unchanged.
- **Reset mid-transaction**
  - Apply `reset`=0 while in REQ on the second coin of 25.
  - `eject_req`=0 immediately. All outputs read 0.
  - A subsequent `start` with 5 completes normally with `paid`=5.

Source files
------------

// File: rtl/change_dispenser_if.sv
// Payout bus between the vending controller, the change dispenser and the
// coin hoppers: request/amount in, per-coin eject handshake, status out.
interface change_dispenser_if #(
    parameter int W = 32
);
    logic         start;
    logic [W-1:0] amount;
    logic [2:0]   empty;
    logic         eject_ack;
    logic         eject_req;
    logic [1:0]   eject_sel;
    logic         busy;
    logic         done;
    logic         fault;
    logic [W-1:0] paid;
    logic [W-1:0] remaining;

    // Controller / hopper side: drives requests and acks, observes status.
    modport master (
        output start, amount, empty, eject_ack,
        input  eject_req, eject_sel, busy, done, fault, paid, remaining
    );

    // Dispenser side.
    modport slave (
        input  start, amount, empty, eject_ack,
        output eject_req, eject_sel, busy, done, fault, paid, remaining
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy change payout over the 10/5/1 coin hoppers. One coin per req/ack
// handshake; hoppers that are empty or never ack are skipped, and whatever
// cannot be paid is left in `remaining` with `fault` raised.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for start; results of last payout held
// SELECT   | pick largest eligible coin, or finish
// REQ      | eject_req high, waiting for ack or hopper timeout
// WAIT_REL | coin counted, waiting for hopper to drop ack
// DONE     | one-cycle done pulse, then back to IDLE
module change_dispenser #(
    parameter int W       = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    change_dispenser_if.slave bus
);
    // Counter only needs to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_10   = 2'b01;
    localparam logic [1:0] SEL_5    = 2'b10;
    localparam logic [1:0] SEL_1    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_REQ,
        S_WAIT_REL,
        S_DONE
    } state_t;

    state_t        state_q,  state_d;
    logic [W-1:0]  rem_q,    rem_d;
    logic [W-1:0]  paid_q,   paid_d;
    logic          fault_q,  fault_d;
    logic          busy_q,   busy_d;
    logic          done_q,   done_d;
    logic          req_q,    req_d;
    logic [1:0]    sel_q,    sel_d;
    logic [2:0]    failed_q, failed_d;
    logic [CW-1:0] cnt_q,    cnt_d;

    logic [W-1:0]  coin;
    logic [2:0]    coin_bit;
    logic [2:0]    elig;

    // Value and hopper-mask bit of the coin currently being requested.
    always_comb begin
        coin     = '0;
        coin_bit = 3'b000;
        case (sel_q)
            SEL_10:  begin coin = W'(10); coin_bit = 3'b100; end
            SEL_5:   begin coin = W'(5);  coin_bit = 3'b010; end
            SEL_1:   begin coin = W'(1);  coin_bit = 3'b001; end
            default: begin coin = '0;     coin_bit = 3'b000; end
        endcase
    end

    // A denomination is eligible if it still fits and its hopper is usable.
    always_comb begin
        elig[2] = (rem_q >= W'(10)) && !bus.empty[2] && !failed_q[2];
        elig[1] = (rem_q >= W'(5))  && !bus.empty[1] && !failed_q[1];
        elig[0] = (rem_q >= W'(1))  && !bus.empty[0] && !failed_q[0];
    end

    // Next-state and next-output computation for the payout sequence.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        paid_d   = paid_q;
        fault_d  = fault_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        req_d    = req_q;
        sel_d    = sel_q;
        failed_d = failed_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    rem_d    = bus.amount;
                    paid_d   = '0;
                    fault_d  = 1'b0;
                    failed_d = 3'b000;
                    busy_d   = 1'b1;
                    state_d  = S_SELECT;
                end
            end
            S_SELECT: begin
                cnt_d = '0;
                if (elig[2]) begin
                    sel_d   = SEL_10;
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end else if (elig[1]) begin
                    sel_d   = SEL_5;
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end else if (elig[0]) begin
                    sel_d   = SEL_1;
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end else begin
                    fault_d = (rem_q != '0);
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_REQ: begin
                // An ack on the final timeout cycle still counts the coin.
                if (bus.eject_ack) begin
                    rem_d   = rem_q - coin;
                    paid_d  = paid_q + coin;
                    req_d   = 1'b0;
                    sel_d   = SEL_NONE;
                    state_d = S_WAIT_REL;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    failed_d = failed_q | coin_bit;
                    req_d    = 1'b0;
                    sel_d    = SEL_NONE;
                    state_d  = S_SELECT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_REL: begin
                if (!bus.eject_ack) begin
                    state_d = S_SELECT;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                req_d   = 1'b0;
                sel_d   = SEL_NONE;
            end
        endcase
    end

    // State and registered outputs; reset drops eject_req immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            rem_q    <= '0;
            paid_q   <= '0;
            fault_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            req_q    <= 1'b0;
            sel_q    <= SEL_NONE;
            failed_q <= 3'b000;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            paid_q   <= paid_d;
            fault_q  <= fault_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            req_q    <= req_d;
            sel_q    <= sel_d;
            failed_q <= failed_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.eject_req = req_q;
    assign bus.eject_sel = sel_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.fault     = fault_q;
    assign bus.paid      = paid_q;
    assign bus.remaining = rem_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: hopper model, eject-order scoreboard and a
// table of payout scenarios plus reset / ignored-start sequences.
module tb_change_dispenser;
    logic clk;
    logic reset;

    change_dispenser_if #(.W(32)) bus ();

    change_dispenser #(.W(32), .TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] amount;
        logic [2:0]  empty;
        logic [2:0]  nack;
        logic [15:0] codes;
        int          ncodes;
        logic [31:0] exp_paid;
        logic [31:0] exp_rem;
        logic        exp_fault;
        int          exp_cyc;
        int          exp_run;
    } vec_t;

    vec_t        vecs [8];
    logic [1:0]  exp_q [$];
    logic [2:0]  nack;
    logic [31:0] cur_amount;
    int          max_run;
    int          n_cmp;
    int          n_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endfunction

    // Hopper model: ack one negedge after req unless that hopper is dead.
    initial begin
        int idx;
        bus.eject_ack = 1'b0;
        forever begin
            @(negedge clk);
            idx = 3 - int'(bus.eject_sel);
            if (bus.eject_req && idx >= 0 && idx <= 2 && !nack[idx])
                bus.eject_ack = 1'b1;
            else if (!bus.eject_req)
                bus.eject_ack = 1'b0;
        end
    end

    // Scoreboard: each new eject request must match the next expected coin.
    initial begin
        logic       prev_req;
        logic [1:0] e;
        int         run;
        prev_req = 1'b0;
        run      = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_req = 1'b0;
                run      = 0;
            end else begin
                if (bus.eject_req) begin
                    if (!prev_req) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL unexpected_eject: got sel %0d, expected no eject", bus.eject_sel);
                        end else begin
                            e = exp_q.pop_front();
                            check("eject_sel", 32'(bus.eject_sel), 32'(e));
                        end
                        run = 0;
                    end
                    run++;
                    if (run > max_run) max_run = run;
                end else begin
                    check("sel_idle", 32'(bus.eject_sel), 32'd0);
                end
                if (bus.busy)
                    check("paid_plus_rem", bus.paid + bus.remaining, cur_amount);
                prev_req = bus.eject_req;
            end
        end
    end

    task automatic launch(input logic [31:0] a, input logic [2:0] e, input logic [2:0] nk,
                          input logic [15:0] codes, input int n);
        @(negedge clk);
        bus.empty  = e;
        nack       = nk;
        for (int i = 0; i < n; i++) exp_q.push_back(codes[2*i +: 2]);
        cur_amount = a;
        max_run    = 0;
        bus.amount = a;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    task automatic finish_tx(input logic [31:0] ep, input logic [31:0] er, input logic ef,
                             input int ecyc, input int erun);
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 2000 && !seen) begin
            @(negedge clk);
            cyc++;
            if (bus.done) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("paid", bus.paid, ep);
            check("remaining", bus.remaining, er);
            check("fault", 32'(bus.fault), 32'(ef));
            if (ecyc != 0) check("done_latency", 32'(cyc), 32'(ecyc));
            @(negedge clk);
            check("done_one_cycle", 32'(bus.done), 32'd0);
            check("busy_after_done", 32'(bus.busy), 32'd0);
            check("paid_hold", bus.paid, ep);
            check("all_coins_ejected", 32'(exp_q.size()), 32'd0);
            if (erun != 0) check("req_run_len", 32'(max_run), 32'(erun));
        end
        exp_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        n_cmp = 0;
        n_err = 0;
        max_run = 0;
        cur_amount = 0;
        nack = 3'b000;

        //        amount  empty   nack    codes (first at LSB)   n  paid    rem    flt cyc run
        vecs[0] = '{32'd37, 3'b000, 3'b000, 16'b0000111110010101, 6, 32'd37, 32'd0, 1'b0, 0, 1};
        vecs[1] = '{32'd15, 3'b100, 3'b000, 16'b0000000000101010, 3, 32'd15, 32'd0, 1'b0, 0, 1};
        vecs[2] = '{32'd3,  3'b001, 3'b000, 16'b0000000000000000, 0, 32'd0,  32'd3, 1'b1, 2, 0};
        vecs[3] = '{32'd0,  3'b000, 3'b000, 16'b0000000000000000, 0, 32'd0,  32'd0, 1'b0, 2, 0};
        vecs[4] = '{32'd10, 3'b000, 3'b100, 16'b0000000000101001, 3, 32'd10, 32'd0, 1'b0, 0, 15};
        vecs[5] = '{32'd17, 3'b000, 3'b001, 16'b0000000000111001, 3, 32'd15, 32'd2, 1'b1, 0, 15};
        vecs[6] = '{32'd11, 3'b000, 3'b000, 16'b0000000000001101, 2, 32'd11, 32'd0, 1'b0, 0, 1};
        vecs[7] = '{32'd8,  3'b010, 3'b000, 16'b1111111111111111, 8, 32'd8,  32'd0, 1'b0, 0, 1};

        reset      = 1'b0;
        bus.start  = 1'b0;
        bus.amount = '0;
        bus.empty  = 3'b000;
        repeat (3) @(negedge clk);
        check("rst_eject_req", 32'(bus.eject_req), 32'd0);
        check("rst_eject_sel", 32'(bus.eject_sel), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_fault", 32'(bus.fault), 32'd0);
        check("rst_paid", bus.paid, 32'd0);
        check("rst_remaining", bus.remaining, 32'd0);
        reset = 1'b1;

        for (int v = 0; v < 8; v++) begin
            launch(vecs[v].amount, vecs[v].empty, vecs[v].nack, vecs[v].codes, vecs[v].ncodes);
            finish_tx(vecs[v].exp_paid, vecs[v].exp_rem, vecs[v].exp_fault,
                      vecs[v].exp_cyc, vecs[v].exp_run);
        end

        // start pulse mid-transaction must not relatch amount
        launch(32'd20, 3'b000, 3'b000, 16'b0000000000000101, 2);
        repeat (3) @(negedge clk);
        bus.amount = 32'd99;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        finish_tx(32'd20, 32'd0, 1'b0, 0, 1);

        // reset while the second coin of 25 is being requested
        launch(32'd25, 3'b000, 3'b000, 16'b0000000000000101, 2);
        cyc = 0;
        while (cyc < 200 && bus.paid != 32'd10) begin
            @(negedge clk);
            cyc++;
        end
        check("first_coin_paid", bus.paid, 32'd10);
        nack = 3'b100;
        cyc = 0;
        while (cyc < 200 && !bus.eject_req) begin
            @(negedge clk);
            cyc++;
        end
        check("second_req_seen", 32'(bus.eject_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_req_drop", 32'(bus.eject_req), 32'd0);
        check("mid_rst_sel", 32'(bus.eject_sel), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_fault", 32'(bus.fault), 32'd0);
        check("mid_rst_paid", bus.paid, 32'd0);
        check("mid_rst_remaining", bus.remaining, 32'd0);
        check("mid_rst_coins", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        nack  = 3'b000;
        launch(32'd5, 3'b000, 3'b000, 16'b0000000000000010, 1);
        finish_tx(32'd5, 32'd0, 1'b0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
